// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory request port between instruction-fetch
// and data requesters, round-robin, one transaction in flight, with timeout.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              ARB_Clk,
    input  logic              ARB_Reset,
    input  logic              ARB_Ins_Req,
    input  logic [ADDR_W-1:0] ARB_Ins_Addr,
    output logic [DATA_W-1:0] ARB_Ins_Rdata,
    output logic              ARB_Ins_Done,
    input  logic              ARB_Dat_Req,
    input  logic              ARB_Dat_We,
    input  logic [ADDR_W-1:0] ARB_Dat_Addr,
    input  logic [DATA_W-1:0] ARB_Dat_Wdata,
    output logic [DATA_W-1:0] ARB_Dat_Rdata,
    output logic              ARB_Dat_Done,
    output logic              ARB_Mem_Valid_Out,
    input  logic              ARB_Mem_Ready_In,
    output logic              ARB_Mem_We,
    output logic [ADDR_W-1:0] ARB_Mem_Addr,
    output logic [DATA_W-1:0] ARB_Mem_Wdata,
    input  logic              ARB_Mem_Rvalid_In,
    input  logic [DATA_W-1:0] ARB_Mem_Rdata,
    output logic              ARB_Error,
    output logic              ARB_Grant,
    output logic [1:0]        ARB_State
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_REQ  = 2'b01;
    localparam logic [1:0] S_RESP = 2'b10;
    localparam logic [1:0] S_DONE = 2'b11;

    // Abort on the edge where the wait counter would reach TIMEOUT_CYC.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);

    logic [1:0]  state;
    logic        last_grant;
    logic [15:0] wait_cnt;
    logic        pick_dat;
    logic        timed_out;

    assign pick_dat  = ARB_Dat_Req && (!ARB_Ins_Req || !last_grant);
    assign timed_out = (wait_cnt == WAIT_LAST);

    assign ARB_State         = state;
    assign ARB_Mem_Valid_Out = (state == S_REQ);
    assign ARB_Ins_Done      = (state == S_DONE) && !ARB_Grant;
    assign ARB_Dat_Done      = (state == S_DONE) && ARB_Grant;

    always_ff @(posedge ARB_Clk) begin
        if (!ARB_Reset) begin
            state         <= S_IDLE;
            last_grant    <= 1'b1;
            wait_cnt      <= '0;
            ARB_Mem_We    <= 1'b0;
            ARB_Mem_Addr  <= '0;
            ARB_Mem_Wdata <= '0;
            ARB_Ins_Rdata <= '0;
            ARB_Dat_Rdata <= '0;
            ARB_Error     <= 1'b0;
            ARB_Grant     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ARB_Ins_Req || ARB_Dat_Req) begin
                        ARB_Grant     <= pick_dat;
                        ARB_Mem_We    <= pick_dat && ARB_Dat_We;
                        ARB_Mem_Addr  <= pick_dat ? ARB_Dat_Addr : ARB_Ins_Addr;
                        ARB_Mem_Wdata <= pick_dat ? ARB_Dat_Wdata : '0;
                        wait_cnt      <= '0;
                        state         <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (ARB_Mem_Ready_In) begin
                        wait_cnt <= '0;
                        state    <= ARB_Mem_We ? S_DONE : S_RESP;
                    end else if (timed_out) begin
                        ARB_Error <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_RESP: begin
                    if (ARB_Mem_Rvalid_In) begin
                        if (ARB_Grant) ARB_Dat_Rdata <= ARB_Mem_Rdata;
                        else           ARB_Ins_Rdata <= ARB_Mem_Rdata;
                        state <= S_DONE;
                    end else if (timed_out) begin
                        ARB_Error <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_DONE: begin
                    last_grant <= ARB_Grant;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: transaction-level scoreboard for mem_arbiter with a
// responsive memory model, directed scenarios and a randomized phase.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ins_req = 1'b0;
    logic [AW-1:0] ins_addr = '0;
    logic [DW-1:0] ins_rdata;
    logic          ins_done;
    logic          dat_req = 1'b0;
    logic          dat_we = 1'b0;
    logic [AW-1:0] dat_addr = '0;
    logic [DW-1:0] dat_wdata = '0;
    logic [DW-1:0] dat_rdata;
    logic          dat_done;
    logic          mem_valid;
    logic          mem_ready = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          err;
    logic          grant;
    logic [1:0]    st;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .ARB_Clk(clk), .ARB_Reset(rst_n),
        .ARB_Ins_Req(ins_req), .ARB_Ins_Addr(ins_addr),
        .ARB_Ins_Rdata(ins_rdata), .ARB_Ins_Done(ins_done),
        .ARB_Dat_Req(dat_req), .ARB_Dat_We(dat_we),
        .ARB_Dat_Addr(dat_addr), .ARB_Dat_Wdata(dat_wdata),
        .ARB_Dat_Rdata(dat_rdata), .ARB_Dat_Done(dat_done),
        .ARB_Mem_Valid_Out(mem_valid), .ARB_Mem_Ready_In(mem_ready),
        .ARB_Mem_We(mem_we), .ARB_Mem_Addr(mem_addr),
        .ARB_Mem_Wdata(mem_wdata), .ARB_Mem_Rvalid_In(mem_rvalid),
        .ARB_Mem_Rdata(mem_rdata), .ARB_Error(err),
        .ARB_Grant(grant), .ARB_State(st)
    );

    typedef struct packed {
        logic          own;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    txn_t          cur;
    bit            in_req, rd_pend, busy, free, free_pend;
    bit            last_own, err_m, done_seen;
    logic [DW-1:0] rdata_m [2];
    int            wcnt, rcnt, vcnt_dut, dec_cyc, lat;
    int            rdy_wait, rv_wait;
    bit            never_rdy, auto_req, keep_req, rand_waits, spur, rd_fix_en;
    logic [DW-1:0] rd_fix;
    bit            own_log[$];

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic tick();
        bit hs, rv, to, dexp;
        logic [DW-1:0] rvd;
        hs  = in_req && mem_ready;
        rv  = rd_pend && mem_rvalid;
        rvd = mem_rdata;
        to  = (in_req && !mem_ready && wcnt + 1 == TO) ||
              (rd_pend && !mem_rvalid && rcnt + 1 == TO);
        // Arbiter is idle this cycle: it will take whichever request rules say.
        if (free && rst_n && (ins_req || dat_req)) begin
            cur.own   = (ins_req && dat_req) ? !last_own : dat_req;
            cur.we    = cur.own && dat_we;
            cur.addr  = cur.own ? dat_addr : ins_addr;
            cur.wdata = dat_wdata;
            free = 0; busy = 1; dec_cyc = cyc; vcnt_dut = 0;
            if (rand_waits) begin
                rdy_wait = $urandom_range(3, 0);
                rv_wait  = $urandom_range(3, 0);
            end
            @(posedge clk); #1;
            cyc++;
            in_req = 1; wcnt = 0;
        end else begin
            @(posedge clk); #1;
            cyc++;
            if (free_pend) begin free = 1; free_pend = 0; end
            dexp = 0;
            if (in_req) begin
                if (hs) begin
                    in_req = 0;
                    if (cur.we) dexp = 1;
                    else begin rd_pend = 1; rcnt = 0; end
                end else if (to) begin
                    in_req = 0; err_m = 1; dexp = 1;
                end else wcnt++;
            end else if (rd_pend) begin
                if (rv) begin
                    rd_pend = 0; rdata_m[cur.own] = rvd; dexp = 1;
                end else if (to) begin
                    rd_pend = 0; err_m = 1; dexp = 1;
                end else rcnt++;
            end
            chk("ins_done", ins_done, dexp && !cur.own);
            chk("dat_done", dat_done, dexp && cur.own);
            chk("state", st, in_req ? 1 : rd_pend ? 2 : dexp ? 3 : 0);
            if (dexp) begin
                done_seen = 1; lat = cyc - dec_cyc; last_own = cur.own;
                busy = 0; free_pend = 1;
                own_log.push_back(cur.own);
                if (!keep_req) begin
                    if (cur.own) dat_req = 0;
                    else ins_req = 0;
                end
            end
        end
        if (mem_valid) vcnt_dut++;
        chk("valid", mem_valid, in_req);
        if (in_req) begin
            chk("grant", grant, cur.own);
            chk("mem_we", mem_we, cur.we);
            chk("mem_addr", mem_addr, cur.addr);
            if (cur.own) chk("mem_wdata", mem_wdata, cur.wdata);
        end
        chk("ins_rdata", ins_rdata, rdata_m[0]);
        chk("dat_rdata", dat_rdata, rdata_m[1]);
        chk("error", err, err_m);
        // Owner scrambles its fields after latching; non-owners may come and go.
        if (busy) begin
            if (cur.own) begin
                dat_addr = $urandom; dat_wdata = $urandom;
                dat_we = 1'($urandom_range(1, 0));
            end else ins_addr = $urandom;
        end
        if (auto_req && rst_n) begin
            if (!ins_req && $urandom_range(1, 0) == 1) begin
                ins_req = 1; ins_addr = $urandom;
            end else if (ins_req && !(busy && !cur.own) && $urandom_range(15, 0) == 0)
                ins_req = 0;
            if (!dat_req && $urandom_range(1, 0) == 1) begin
                dat_req = 1; dat_addr = $urandom; dat_wdata = $urandom;
                dat_we = 1'($urandom_range(1, 0));
            end else if (dat_req && !(busy && cur.own) && $urandom_range(15, 0) == 0)
                dat_req = 0;
        end
        mem_ready  = in_req && !never_rdy && wcnt >= rdy_wait;
        mem_rvalid = rd_pend ? (rcnt >= rv_wait) : (spur && $urandom_range(3, 0) == 0);
        mem_rdata  = rd_fix_en ? rd_fix : $urandom;
    endtask

    task automatic do_reset(int n);
        rst_n = 0; ins_req = 0; dat_req = 0; mem_ready = 0; mem_rvalid = 0;
        in_req = 0; rd_pend = 0; busy = 0; free = 0; free_pend = 0;
        err_m = 0; last_own = 1; rdata_m[0] = '0; rdata_m[1] = '0;
        repeat (n) tick();
        chk("rst_grant", grant, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        rst_n = 1; free = 1;
    endtask

    task automatic run_txn(int bound);
        done_seen = 0;
        for (int i = 0; i < bound && !done_seen; i++) tick();
        chk("done_seen", done_seen, 1);
    endtask

    initial begin
        rdy_wait = 0; rv_wait = 0; never_rdy = 0; auto_req = 0; keep_req = 0;
        rand_waits = 0; spur = 0; rd_fix_en = 0; rd_fix = '0;
        do_reset(2);

        // Zero-wait fetch read.
        rd_fix_en = 1; rd_fix = 32'hDEADBEEF;
        ins_addr = 32'h100; ins_req = 1;
        run_txn(20);
        chk("rd_latency", lat, 3);
        chk("rd_data", ins_rdata, 32'hDEADBEEF);

        // Both held: grants alternate starting with fetch.
        do_reset(1);
        own_log.delete();
        keep_req = 1; ins_req = 1; dat_req = 1; dat_we = 0;
        repeat (4) run_txn(20);
        keep_req = 0; ins_req = 0; dat_req = 0;
        chk("rr_len", own_log.size(), 4);
        for (int i = 0; i < 4 && i < own_log.size(); i++)
            chk("rr_order", own_log[i], i % 2);

        // Data read, then a write stalled 4 cycles.
        rd_fix = 32'h12345678;
        dat_we = 0; dat_addr = 32'h300; dat_req = 1;
        run_txn(20);
        repeat (2) tick();
        rdy_wait = 4;
        dat_we = 1; dat_addr = 32'h200; dat_wdata = 32'h55; dat_req = 1;
        run_txn(20);
        chk("wr_latency", lat, 6);
        chk("wr_valid_cycles", vcnt_dut, 5);
        chk("wr_rdata_kept", dat_rdata, 32'h12345678);
        rdy_wait = 0;

        // Timeout, then a normal transaction with the error still set.
        never_rdy = 1; ins_addr = 32'h500; ins_req = 1;
        run_txn(30);
        chk("to_error", err, 1);
        chk("to_req_cycles", vcnt_dut, TO);
        chk("to_rdata_kept", ins_rdata, 32'h12345678 ^ 32'h12345678 ^ 32'hDEADBEEF);
        never_rdy = 0; rd_fix = 32'hCAFEF00D; ins_addr = 32'h504; ins_req = 1;
        run_txn(20);
        chk("after_to_rdata", ins_rdata, 32'hCAFEF00D);
        chk("after_to_error", err, 1);

        // Reset while waiting for read data, then a stray rvalid.
        rv_wait = 5; rd_fix = 32'hAAAA5555;
        ins_addr = 32'h400; ins_req = 1;
        for (int i = 0; i < 10 && !rd_pend; i++) tick();
        chk("resp_reached", rd_pend, 1);
        tick();
        do_reset(1);
        mem_rvalid = 1;
        tick();
        chk("rst_ins_rdata", ins_rdata, 0);
        chk("rst_idle", st, 0);
        rv_wait = 0;

        // Randomized traffic.
        auto_req = 1; rand_waits = 1; spur = 1; rd_fix_en = 0;
        repeat (2000) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
